// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state type and default depth for the I2C register bank
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PTR   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } i2c_state_t;

   localparam int I2C_DEFAULT_DEPTH = 16;

endpackage

// File: rtl/i2c_reg_bank_mem.sv
// rtl/i2c_reg_bank_mem.sv - byte register storage: one write port (host wins), async and registered read ports
module i2c_reg_bank_mem
   import i2c_pkg::*;
#(
   parameter int DEPTH = I2C_DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          pclk,
   input  logic          presetn,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   input  logic          i2c_we,
   input  logic [AW-1:0] i2c_addr,
   input  logic [7:0]    i2c_wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [7:0]    rdata_a,
   input  logic [AW-1:0] raddr_q,
   output logic [7:0]    rdata_q
);

   logic [7:0] mem [DEPTH];

   // The registered port samples the array before this edge's write lands,
   // so a change becomes visible on rdata_q one cycle later.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         rdata_q <= 8'h00;
      end else begin
         if (host_we) begin
            mem[host_addr] <= host_wdata;
         end else if (i2c_we) begin
            mem[i2c_addr] <= i2c_wdata;
         end
         rdata_q <= mem[raddr_q];
      end
   end

   assign rdata_a = mem[raddr_a];

endmodule

// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - I2C slave register bank; I2C_REG_BANK_WRAP_EN selects pointer wrap, else saturate with ovf
module i2c_reg_bank
   import i2c_pkg::*;
#(
   parameter int DEPTH = I2C_DEFAULT_DEPTH,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          pclk,
   input  logic          presetn,
   input  logic          evt_start,
   input  logic          evt_stop,
   input  logic          addr_hit,
   input  logic          rw,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          tx_ack,
   output logic [7:0]    tx_data,
   input  logic          host_we,
   input  logic [PW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata,
   output logic          wr_evt,
   output logic [PW-1:0] wr_idx,
   output logic [PW-1:0] ptr,
   output logic          ovf
);

   i2c_state_t    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] wr_idx_q, wr_idx_d;
   logic          wr_evt_q, wr_evt_d;
   logic          ovf_q, ovf_d;
   logic          sat_q, sat_d;
   logic          i2c_we;
   logic          adv_req;
   logic          adv_end;
   logic [PW-1:0] adv_ptr;

   assign adv_end = (ptr_q == PW'(DEPTH - 1));

`ifdef I2C_REG_BANK_WRAP_EN
   assign adv_ptr = adv_end ? '0 : ptr_q + PW'(1);
`else
   assign adv_ptr = adv_end ? ptr_q : ptr_q + PW'(1);
`endif

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         wr_idx_q <= '0;
         wr_evt_q <= 1'b0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         wr_idx_q <= wr_idx_d;
         wr_evt_q <= wr_evt_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
      end
   end

   // sat_q blocks further writes after the pointer pinned at the top; only a new
   // pointer load clears it, whereas ovf is cleared by any START.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      wr_idx_d = wr_idx_q;
      wr_evt_d = 1'b0;
      ovf_d    = ovf_q;
      sat_d    = sat_q;
      i2c_we   = 1'b0;
      adv_req  = 1'b0;

      if (evt_start) begin
         ovf_d = 1'b0;
      end

      unique case (state_q)
         ST_PTR: begin
            if (rx_valid) begin
               ptr_d   = rx_data[PW-1:0];
               sat_d   = 1'b0;
               state_d = ST_WDATA;
            end
         end
         ST_WDATA: begin
            if (rx_valid && !sat_q) begin
               i2c_we   = 1'b1;
               wr_evt_d = 1'b1;
               wr_idx_d = ptr_q;
               adv_req  = 1'b1;
            end
         end
         ST_RDATA: begin
            if (tx_ack) begin
               adv_req = 1'b1;
            end
         end
         default: begin
         end
      endcase

      if (adv_req) begin
         ptr_d = adv_ptr;
`ifdef I2C_REG_BANK_WRAP_EN
`else
         if (adv_end) begin
            ovf_d = 1'b1;
            sat_d = 1'b1;
         end
`endif
      end

      // A byte arriving with STOP has already been handled above.
      if (evt_stop) begin
         state_d = ST_IDLE;
      end
      if (addr_hit) begin
         state_d = rw ? ST_RDATA : ST_PTR;
      end
   end

   i2c_reg_bank_mem #(
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .pclk       (pclk),
      .presetn    (presetn),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .i2c_we     (i2c_we),
      .i2c_addr   (ptr_q),
      .i2c_wdata  (rx_data),
      .raddr_a    (host_addr),
      .rdata_a    (host_rdata),
      .raddr_q    (ptr_q),
      .rdata_q    (tx_data)
   );

   assign ptr    = ptr_q;
   assign wr_evt = wr_evt_q;
   assign wr_idx = wr_idx_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb/tb_i2c_reg_bank.sv - scoreboard bench for i2c_reg_bank with a byte-level reference model
module tb_i2c_reg_bank;
   import i2c_pkg::*;

   localparam int DEPTH = I2C_DEFAULT_DEPTH;
   localparam int PW    = $clog2(DEPTH);

   logic          pclk = 1'b0;
   logic          presetn = 1'b0;
   logic          evt_start = 1'b0;
   logic          evt_stop = 1'b0;
   logic          addr_hit = 1'b0;
   logic          rw = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_ack = 1'b0;
   logic [7:0]    tx_data;
   logic          host_we = 1'b0;
   logic [PW-1:0] host_addr = '0;
   logic [7:0]    host_wdata = 8'h00;
   logic [7:0]    host_rdata;
   logic          wr_evt;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] ptr;
   logic          ovf;

   i2c_reg_bank #(.DEPTH(DEPTH)) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .evt_start  (evt_start),
      .evt_stop   (evt_stop),
      .addr_hit   (addr_hit),
      .rw         (rw),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_ack     (tx_ack),
      .tx_data    (tx_data),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .wr_evt     (wr_evt),
      .wr_idx     (wr_idx),
      .ptr        (ptr),
      .ovf        (ovf)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: mode 0 idle, 1 expecting pointer, 2 writing, 3 reading
   int mem_m [DEPTH];
   int ptr_m;
   int mode_m;
   bit ovf_m;
   bit blk_m;
   int wr_q [$];
   int tx_q [$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(negedge pclk) begin
      if (presetn) begin
         if (wr_evt) begin
            if (wr_q.size() == 0) check("wr_evt_unexpected", 1, 0);
            else check("wr_idx", int'(wr_idx), wr_q.pop_front());
         end
         if (tx_ack) begin
            if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
            else check("tx_data", int'(tx_data), tx_q.pop_front());
         end
      end
   end

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
      ptr_m = 0; mode_m = 0; ovf_m = 0; blk_m = 0;
   endtask

   task automatic m_advance();
      if (ptr_m == DEPTH - 1) begin
`ifdef I2C_REG_BANK_WRAP_EN
         ptr_m = 0;
`else
         ovf_m = 1'b1;
         blk_m = 1'b1;
`endif
      end else begin
         ptr_m++;
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      tick();
      presetn = 1'b1;
      tick();
      m_reset();
   endtask

   task automatic do_start();
      ovf_m = 1'b0;
      evt_start = 1'b1; tick(); evt_start = 1'b0; tick();
   endtask

   task automatic do_stop();
      mode_m = 0;
      evt_stop = 1'b1; tick(); evt_stop = 1'b0; tick();
   endtask

   task automatic do_addr(input bit r);
      mode_m = r ? 3 : 1;
      addr_hit = 1'b1; rw = r; tick(); addr_hit = 1'b0; rw = 1'b0; tick();
   endtask

   task automatic do_byte(input logic [7:0] b, input bit with_stop);
      case (mode_m)
         1: begin ptr_m = int'(b) % DEPTH; blk_m = 1'b0; mode_m = 2; end
         2: if (!blk_m) begin mem_m[ptr_m] = int'(b); wr_q.push_back(ptr_m); m_advance(); end
         default: ;
      endcase
      if (with_stop) mode_m = 0;
      rx_data = b; rx_valid = 1'b1; evt_stop = with_stop;
      tick();
      rx_valid = 1'b0; evt_stop = 1'b0;
      tick();
   endtask

   task automatic do_ack();
      tx_q.push_back(mem_m[ptr_m]);
      if (mode_m == 3) m_advance();
      tx_ack = 1'b1; tick(); tx_ack = 1'b0; tick();
   endtask

   task automatic do_host(input int idx, input logic [7:0] d);
      mem_m[idx] = int'(d);
      host_addr = PW'(idx); host_wdata = d; host_we = 1'b1;
      tick();
      host_we = 1'b0;
      tick();
   endtask

   task automatic check_mem(input int idx);
      host_addr = PW'(idx);
      #1;
      check($sformatf("mem[%0d]", idx), int'(host_rdata), mem_m[idx]);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_ptr"}, int'(ptr), ptr_m);
      check({tag, "_ovf"}, int'(ovf), int'(ovf_m));
      check({tag, "_wr_pending"}, wr_q.size(), 0);
      check({tag, "_tx_pending"}, tx_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      m_reset();
      tick();
      do_reset();
      check("reset_tx_data", int'(tx_data), 0);
      check("reset_wr_evt", int'(wr_evt), 0);
      check("reset_wr_idx", int'(wr_idx), 0);
      check_state("reset");

      // Pointer 3 then two data bytes
      do_start(); do_addr(1'b0);
      do_byte(8'h03, 1'b0); do_byte(8'hAA, 1'b0); do_byte(8'hBB, 1'b0);
      do_stop();
      check_mem(3); check_mem(4);
      check("w35_ptr5", int'(ptr), 5);
      check_state("w35");

      // Combined pointer write then repeated-start read of three bytes
      do_host(2, 8'h21);
      do_start(); do_addr(1'b0); do_byte(8'h02, 1'b0);
      do_start(); do_addr(1'b1);
      do_ack(); do_ack(); do_ack();
      do_stop();
      check("r36_ptr5", int'(ptr), 5);
      check_state("r36");

      // Run past the top of the bank
      do_start(); do_addr(1'b0);
      do_byte(8'h0F, 1'b0); do_byte(8'h11, 1'b0); do_byte(8'h22, 1'b0);
      do_stop();
      check_mem(15); check_mem(0);
`ifdef I2C_REG_BANK_WRAP_EN
      check("edge_ovf_wrap", int'(ovf), 0);
`else
      check("edge_ovf_sat", int'(ovf), 1);
`endif
      check_state("edge");

      // Host and I2C write to index 4 in the same cycle: host data wins
      do_start(); do_addr(1'b0); do_byte(8'h04, 1'b0);
      mem_m[4] = 8'h55; wr_q.push_back(4); ptr_m = 5;
      rx_data = 8'h66; rx_valid = 1'b1;
      host_addr = PW'(4); host_wdata = 8'h55; host_we = 1'b1;
      tick();
      rx_valid = 1'b0; host_we = 1'b0;
      tick();
      do_stop();
      check_mem(4);
      check_state("collide");

      // Stray byte in IDLE must be ignored
      do_byte(8'h99, 1'b0);
      check_state("idle_rx");
      check_mem(9);

      // Byte arriving with STOP is written, the following one is ignored
      do_start(); do_addr(1'b0); do_byte(8'h08, 1'b0);
      do_byte(8'h77, 1'b1); do_byte(8'h78, 1'b0);
      check_mem(8); check_mem(9);
      check_state("stop_rx");

      // Randomised transfers
      for (int it = 0; it < 60; it++) begin
         int op;
         op = int'($urandom_range(0, 4));
         case (op)
            0: begin
               int n;
               do_start(); do_addr(1'b0);
               do_byte(8'($urandom), 1'b0);
               n = int'($urandom_range(0, 5));
               for (int k = 0; k < n; k++) do_byte(8'($urandom), 1'b0);
               if ($urandom_range(0, 1) == 1) do_byte(8'($urandom), 1'b1);
               else do_stop();
            end
            1: begin
               int n;
               do_start(); do_addr(1'b0); do_byte(8'($urandom), 1'b0);
               do_start(); do_addr(1'b1);
               n = int'($urandom_range(1, 5));
               for (int k = 0; k < n; k++) do_ack();
               do_stop();
            end
            2: do_host(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            3: begin
               int n;
               do_start(); do_addr(1'b1);
               n = int'($urandom_range(1, 4));
               for (int k = 0; k < n; k++) do_ack();
               do_stop();
            end
            default: begin
               if ($urandom_range(0, 1) == 1) do_byte(8'($urandom), 1'b0);
               else do_ack();
            end
         endcase
      end
      check_state("random");
      for (int i = 0; i < DEPTH; i++) check_mem(i);

      // Reset in the middle of a write transfer
      do_start(); do_addr(1'b0); do_byte(8'h07, 1'b0); do_byte(8'h12, 1'b0);
      check_mem(7);
      do_reset();
      check("rst_mid_tx_data", int'(tx_data), 0);
      check("rst_mid_wr_idx", int'(wr_idx), 0);
      check_mem(7);
      check_state("rst_mid");
      do_byte(8'h55, 1'b0);
      check_mem(5);
      check_state("rst_idle");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_reg_bank.md
I2C_REG_BANK -- requirements
Module: i2c_reg_bank

Interface
REQ-001 Parameter DEPTH, default 16, number of byte registers; SHALL be a power of two, 2..256.
REQ-002 Parameter PW, default $clog2(DEPTH), register pointer width (derived, not overridden).
REQ-003 pclk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 presetn  in  1  reset; one clock, reset is synchronous and active-low.
REQ-005 evt_start  in  1  one-cycle pulse on START or repeated START from the I2C slave.
REQ-006 evt_stop  in  1  one-cycle pulse on STOP.
REQ-007 addr_hit  in  1  one-cycle pulse when the slave address matched and was ACKed.
REQ-008 rw  in  1  R/W bit of the matched address, valid with addr_hit (1 = read).
REQ-009 rx_valid  in  1  one-cycle pulse: rx_data holds an ACKed received byte.
REQ-010 rx_data  in  8  received byte.
REQ-011 tx_ack  in  1  one-cycle pulse: the byte on tx_data was sent and ACKed by the master.
REQ-012 tx_data  out  8  next byte to transmit, registered.
REQ-013 host_we  in  1  local host write strobe.
REQ-014 host_addr  in  PW  local host register index.
REQ-015 host_wdata  in  8  local host write data.
REQ-016 host_rdata  out  8  mem[host_addr], combinational.
REQ-017 wr_evt  out  1  one-cycle pulse when an I2C write updates a register.
REQ-018 wr_idx  out  PW  index written, valid with wr_evt.
REQ-019 ptr  out  PW  current register pointer.
REQ-020 ovf  out  1  sticky: pointer ran past DEPTH-1 (saturating build only); cleared on evt_start.

Function
REQ-021 FSM states IDLE, PTR, WDATA, RDATA; reset state IDLE.
REQ-022 addr_hit with rw=0 SHALL go to PTR from any state; addr_hit with rw=1 SHALL go to RDATA from any state.
REQ-023 In PTR, rx_valid SHALL load ptr <= rx_data[PW-1:0] and go to WDATA; no register write.
REQ-024 In WDATA, rx_valid SHALL write mem[ptr] <= rx_data, pulse wr_evt with wr_idx = ptr next cycle, and advance ptr.
REQ-025 In RDATA, tx_ack SHALL advance ptr; tx_data SHALL equal mem[ptr] one cycle after any ptr or mem change.
REQ-026 evt_stop SHALL return to IDLE; evt_start alone SHALL NOT change ptr (combined write-pointer/read supported).
REQ-027 rx_valid in IDLE or RDATA, and tx_ack outside RDATA, SHALL be ignored.
REQ-028 Simultaneous host_we and I2C write to the same index: host data SHALL win; wr_evt still pulses.
REQ-029 evt_stop in the same cycle as rx_valid: byte SHALL be processed first, then IDLE.

Reset
REQ-030 presetn low at a rising pclk edge SHALL set state IDLE, ptr 0, all mem 0, tx_data 0x00, wr_evt 0, wr_idx 0, ovf 0, including mid-transfer.

Configuration
REQ-031 Macro I2C_REG_BANK_WRAP_EN defined: ptr advance from DEPTH-1 SHALL wrap to 0; ovf SHALL stay 0.
REQ-032 Macro undefined: ptr SHALL saturate at DEPTH-1, set ovf, and further WDATA writes SHALL be dropped (no wr_evt) until the next PTR load.

Structure
REQ-033 Package i2c_pkg SHALL hold the FSM state typedef and the default DEPTH constant.
REQ-034 Storage SHALL be a sub-module i2c_reg_bank_mem (one sync write port with host priority, one async read port, one registered read port).

Verification
REQ-035 Write 0x03,0xAA,0xBB (DEPTH=16) -> mem[3]=0xAA, mem[4]=0xBB, ptr=5, two wr_evt with wr_idx 3,4.
REQ-036 Write ptr 0x02, repeated start, read, 3 tx_ack -> tx_data sequence mem[2],mem[3],mem[4], ptr=5.
REQ-037 Write ptr 0x0F then 0x11,0x22 -> WRAP_EN: mem[15]=0x11, mem[0]=0x22, ovf=0; no macro: mem[15]=0x11, mem[0] unchanged, ovf=1, one wr_evt.
REQ-038 host_we idx 4 data 0x55 same cycle as I2C write idx 4 data 0x66 -> mem[4]=0x55, wr_evt=1, wr_idx=4.
REQ-039 presetn low during WDATA after ptr 0x07 -> state IDLE, ptr 0, mem[7]=0x00, tx_data 0x00.
REQ-040 rx_valid 0x99 in IDLE with no addr_hit -> no mem change, no wr_evt, ptr unchanged.
